// File: rtl/scim_jtag_mem_bridge.sv
// scim_jtag_mem_bridge: turns synchronised JTAG DR commands into ACT-bank memory cycles and a compute-start pulse.
// Optional feature macro: SCIM_MEMBR_WRCNT_EN adds the o_wr_count completed-write counter.
module scim_jtag_mem_bridge #(
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_cmd_valid,
    output logic                        o_cmd_ready,
    input  logic [1:0]                  i_cmd_op,
    input  logic [BANK_W-1:0]           i_cmd_bank,
    input  logic [ADDR_W-1:0]           i_cmd_addr,
    input  logic [DATA_W-1:0]           i_cmd_wdata,
    output logic [NUM_BANKS-1:0]        o_mem_cs,
    output logic                        o_mem_we,
    output logic [ADDR_W-1:0]           o_mem_addr,
    output logic [DATA_W-1:0]           o_mem_wdata,
    input  logic [NUM_BANKS*DATA_W-1:0] i_mem_rdata,
    output logic                        o_rsp_valid,
    input  logic                        i_rsp_ready,
    output logic [DATA_W-1:0]           o_rsp_data,
    output logic                        o_start,
    output logic                        o_err
`ifdef SCIM_MEMBR_WRCNT_EN
    ,
    output logic [31:0]                 o_wr_count
`endif
);

    localparam logic [1:0] OP_WRITE   = 2'd0;
    localparam logic [1:0] OP_READ    = 2'd1;
    localparam logic [1:0] OP_SETADDR = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_REQ,
        S_RD_WAIT,
        S_RSP
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [BANK_W-1:0]   r_bank;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [2:0]          r_lat_cnt;
    logic                r_start;
    logic                r_err;
    logic                w_accept;
    logic                w_bank_bad;
    logic                w_lat_done;

    assign w_accept   = i_cmd_valid && (r_state == S_IDLE) && !i_reset;
    assign w_bank_bad = ({1'b0, i_cmd_bank} >= (BANK_W+1)'(NUM_BANKS));
    assign w_lat_done = (r_lat_cnt == 3'(RD_LAT));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A READ to a nonexistent bank skips the memory and answers zero straight from RSP.
    always_comb begin
        w_next_state = r_state;
        o_cmd_ready  = 1'b0;
        o_mem_cs     = '0;
        o_mem_we     = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_rsp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_cmd_ready = !i_reset;
                if (w_accept) begin
                    case (i_cmd_op)
                        OP_WRITE: if (!w_bank_bad) w_next_state = S_WR;
                        OP_READ:  w_next_state = w_bank_bad ? S_RSP : S_RD_REQ;
                        default:  w_next_state = S_IDLE;
                    endcase
                end
            end
            S_WR: begin
                o_mem_cs     = NUM_BANKS'(1) << r_bank;
                o_mem_we     = 1'b1;
                o_mem_addr   = r_ptr;
                o_mem_wdata  = r_wdata;
                w_next_state = S_IDLE;
            end
            S_RD_REQ: begin
                o_mem_cs     = NUM_BANKS'(1) << r_bank;
                o_mem_addr   = r_ptr;
                w_next_state = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (w_lat_done) w_next_state = S_RSP;
            end
            S_RSP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr      <= '0;
            r_bank     <= '0;
            r_wdata    <= '0;
            r_rsp_data <= '0;
            r_lat_cnt  <= '0;
            r_start    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_start <= 1'b0;
            if (w_accept) begin
                case (i_cmd_op)
                    OP_WRITE, OP_READ: begin
                        if (w_bank_bad) begin
                            r_err      <= 1'b1;
                            r_rsp_data <= '0;
                        end else begin
                            r_bank  <= i_cmd_bank;
                            r_wdata <= i_cmd_wdata;
                        end
                    end
                    OP_SETADDR: r_ptr <= i_cmd_addr;
                    default:    r_start <= 1'b1;
                endcase
            end
            if (r_state == S_WR || r_state == S_RD_REQ) begin
                r_ptr <= r_ptr + ADDR_W'(1);
            end
            // The wait spans RD_LAT+1 cycles so the memory output has settled before capture.
            if (r_state == S_RD_WAIT) begin
                if (w_lat_done) begin
                    r_rsp_data <= i_mem_rdata[int'(r_bank)*DATA_W +: DATA_W];
                    r_lat_cnt  <= '0;
                end else begin
                    r_lat_cnt <= r_lat_cnt + 3'd1;
                end
            end
        end
    end

    assign o_rsp_data = r_rsp_data;
    assign o_start    = r_start;
    assign o_err      = r_err;

`ifdef SCIM_MEMBR_WRCNT_EN
    logic [31:0] r_wr_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_count <= '0;
        end else if (w_accept && i_cmd_op == OP_SETADDR) begin
            r_wr_count <= '0;
        end else if (r_state == S_WR && r_wr_count != 32'hFFFF_FFFF) begin
            r_wr_count <= r_wr_count + 32'd1;
        end
    end

    assign o_wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_scim_jtag_mem_bridge.sv
// tb_scim_jtag_mem_bridge: scoreboard bench with a behavioural command model and a simple banked memory.
// Build with SCIM_MEMBR_WRCNT_EN defined to also check o_wr_count.
module tb_scim_jtag_mem_bridge;
    localparam int NUM_BANKS = 4;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int RD_LAT    = 2;
    localparam int BANK_W    = 3;
    localparam int DEPTH     = 1 << ADDR_W;
    localparam logic [1:0] OP_WRITE = 2'd0, OP_READ = 2'd1, OP_SETADDR = 2'd2, OP_START = 2'd3;

    typedef struct {
        bit          isWrite;
        int          bank;
        int          addr;
        logic [31:0] data;
    } acc_t;

    typedef struct {
        logic [31:0] data;
        int          riseCyc;
    } rsp_t;

    logic                        clk = 1'b0;
    logic                        i_reset;
    logic                        i_cmd_valid;
    logic                        o_cmd_ready;
    logic [1:0]                  i_cmd_op;
    logic [BANK_W-1:0]           i_cmd_bank;
    logic [ADDR_W-1:0]           i_cmd_addr;
    logic [DATA_W-1:0]           i_cmd_wdata;
    logic [NUM_BANKS-1:0]        o_mem_cs;
    logic                        o_mem_we;
    logic [ADDR_W-1:0]           o_mem_addr;
    logic [DATA_W-1:0]           o_mem_wdata;
    logic [NUM_BANKS*DATA_W-1:0] i_mem_rdata;
    logic                        o_rsp_valid;
    logic                        i_rsp_ready;
    logic [DATA_W-1:0]           o_rsp_data;
    logic                        o_start;
    logic                        o_err;
`ifdef SCIM_MEMBR_WRCNT_EN
    logic [31:0]                 o_wr_count;
`endif

    int numCompared   = 0;
    int numMismatched = 0;
    int cyc           = 0;

    acc_t        accQ[$];
    rsp_t        rspQ[$];
    logic [31:0] refMem[int];
    int          refPtr;
    bit          refErr;
    longint      refWrCount;
    int          startsIssued = 0;
    int          startsSeen   = 0;
    bit          holdReadyLow = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    scim_jtag_mem_bridge #(
        .NUM_BANKS(NUM_BANKS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .BANK_W(BANK_W)
    ) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_op(i_cmd_op),
        .i_cmd_bank(i_cmd_bank), .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata),
        .o_mem_cs(o_mem_cs), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_data(o_rsp_data), .o_start(o_start), .o_err(o_err)
`ifdef SCIM_MEMBR_WRCNT_EN
        , .o_wr_count(o_wr_count)
`endif
    );

    function automatic logic [31:0] initWord(int b, int a);
        logic [31:0] key;
        key = 32'(b * DEPTH + a + 1);
        return key * 32'h9E37_79B9;
    endfunction

    function automatic logic [31:0] refRead(int b, int a);
        if (refMem.exists(b * DEPTH + a)) return refMem[b * DEPTH + a];
        return initWord(b, a);
    endfunction

    function automatic logic [63:0] packAcc(bit w, int bank, int addr, logic [31:0] data);
        return {17'b0, w, 4'(bank), 10'(addr), data};
    endfunction

    task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
        numCompared++;
        if (actual !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Simple banked memory: writes land immediately, reads appear RD_LAT cycles after the request.
    logic [DATA_W-1:0] benchMem [NUM_BANKS][DEPTH];
    logic [DATA_W-1:0] bankOut  [NUM_BANKS];
    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_rdata
        assign i_mem_rdata[g*DATA_W +: DATA_W] = bankOut[g];
    end

    initial begin
        int pend;
        int pBank;
        int pAddr;
        pend = 0;
        pBank = 0;
        pAddr = 0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bankOut[b] = '0;
            for (int a = 0; a < DEPTH; a++) benchMem[b][a] = initWord(b, a);
        end
        forever begin
            @(negedge clk);
            if (pend > 0) begin
                pend--;
                if (pend == 0) bankOut[pBank] = benchMem[pBank][pAddr];
            end
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (o_mem_cs[b] === 1'b1 && i_reset === 1'b0) begin
                    if (o_mem_we) begin
                        benchMem[b][o_mem_addr] = o_mem_wdata;
                    end else begin
                        pend  = RD_LAT;
                        pBank = b;
                        pAddr = int'(o_mem_addr);
                    end
                end
            end
        end
    end

    initial begin
        i_rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            i_rsp_ready = holdReadyLow ? 1'b0 : ($urandom_range(0, 9) < 4);
        end
    end

    // Monitor: every memory cycle, start pulse and response is matched against the scoreboard.
    bit          rspSeenPrev = 1'b0;
    logic [31:0] heldData;
    always @(negedge clk) begin
        acc_t exp;
        rsp_t er;
        int   csBank;
        if (i_reset !== 1'b0) begin
            rspSeenPrev = 1'b0;
        end else begin
            if (o_mem_cs != '0) begin
                checkOutput("mem_cs_onehot", 64'($onehot(o_mem_cs)), 64'd1);
                if (o_start) checkOutput("start_cs_overlap", 64'd1, 64'd0);
                csBank = 0;
                for (int b = 0; b < NUM_BANKS; b++) if (o_mem_cs[b]) csBank = b;
                if (accQ.size() == 0) begin
                    checkOutput("mem_unexpected", packAcc(o_mem_we, csBank, int'(o_mem_addr), 32'h0), 64'h0);
                end else begin
                    exp = accQ.pop_front();
                    checkOutput("mem_access",
                        packAcc(o_mem_we, csBank, int'(o_mem_addr), o_mem_we ? o_mem_wdata : 32'h0),
                        packAcc(exp.isWrite, exp.bank, exp.addr, exp.isWrite ? exp.data : 32'h0));
                end
            end
            if (o_start) begin
                checkOutput("start_expected", 64'(startsSeen < startsIssued), 64'd1);
                startsSeen++;
            end
            if (o_rsp_valid) begin
                if (!rspSeenPrev) begin
                    if (rspQ.size() == 0) checkOutput("rsp_unexpected", 64'd1, 64'd0);
                    else if (rspQ[0].riseCyc >= 0) checkOutput("rsp_latency", 64'(cyc), 64'(rspQ[0].riseCyc));
                end else begin
                    checkOutput("rsp_stable", 64'(o_rsp_data), 64'(heldData));
                end
                heldData = o_rsp_data;
                if (i_rsp_ready) begin
                    if (rspQ.size() > 0) begin
                        er = rspQ.pop_front();
                        checkOutput("rsp_data", 64'(o_rsp_data), 64'(er.data));
                    end
                    rspSeenPrev = 1'b0;
                end else begin
                    rspSeenPrev = 1'b1;
                end
            end else begin
                rspSeenPrev = 1'b0;
            end
        end
    end

    task automatic modelReset();
        refPtr     = 0;
        refErr     = 1'b0;
        refWrCount = 0;
    endtask

    task automatic modelAccept(logic [1:0] op, int bank, int addr, logic [31:0] wdata);
        bit bad;
        bad = (bank >= NUM_BANKS);
        case (op)
            OP_WRITE: begin
                if (bad) begin
                    refErr = 1'b1;
                end else begin
                    accQ.push_back('{1'b1, bank, refPtr, wdata});
                    refMem[bank * DEPTH + refPtr] = wdata;
                    refPtr = (refPtr + 1) % DEPTH;
                    if (refWrCount < 64'hFFFF_FFFF) refWrCount++;
                end
            end
            OP_READ: begin
                if (bad) begin
                    refErr = 1'b1;
                    rspQ.push_back('{32'h0, -1});
                end else begin
                    accQ.push_back('{1'b0, bank, refPtr, 32'h0});
                    rspQ.push_back('{refRead(bank, refPtr), cyc + 1 + RD_LAT + 2});
                    refPtr = (refPtr + 1) % DEPTH;
                end
            end
            OP_SETADDR: begin
                refPtr     = addr;
                refWrCount = 0;
            end
            default: startsIssued++;
        endcase
    endtask

    // Drives one command and waits (bounded) for it to be accepted; returns at posedge+1.
    task automatic applyStimulus(logic [1:0] op, int bank, int addr, logic [31:0] wdata);
        bit accepted;
        accepted    = 1'b0;
        i_cmd_op    = op;
        i_cmd_bank  = BANK_W'(bank);
        i_cmd_addr  = ADDR_W'(addr);
        i_cmd_wdata = wdata;
        i_cmd_valid = 1'b1;
        for (int w = 0; w < 64; w++) begin
            @(negedge clk);
            if (o_cmd_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            checkOutput("cmd_accept_timeout", 64'd0, 64'd1);
        end else begin
            modelAccept(op, bank, addr, wdata);
        end
        @(posedge clk);
        #1;
        i_cmd_valid = 1'b0;
    endtask

    task automatic waitIdle();
        bit idle;
        idle = 1'b0;
        for (int w = 0; w < 300; w++) begin
            @(posedge clk);
            #1;
            if (o_cmd_ready && !o_rsp_valid && accQ.size() == 0 && rspQ.size() == 0 &&
                startsSeen == startsIssued) begin
                idle = 1'b1;
                break;
            end
        end
        if (!idle) checkOutput("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic checkResetOutputs(string tag);
        checkOutput({tag, "_ctrl"},
            64'({o_cmd_ready, o_mem_cs, o_mem_we, o_rsp_valid, o_start, o_err, o_mem_addr}), 64'd0);
        checkOutput({tag, "_data"}, {o_mem_wdata, o_rsp_data}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] op;
        int         r;
        int         bank;
        int         addr;
        bit         seen;

        i_reset     = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_op    = '0;
        i_cmd_bank  = '0;
        i_cmd_addr  = '0;
        i_cmd_wdata = '0;
        modelReset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset_init");
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", 64'(o_cmd_ready), 64'd1);
        @(posedge clk);
        #1;

        // Reset in the middle of a READ: no response must ever appear.
        applyStimulus(OP_READ, 1, 0, 32'h0);
        @(posedge clk);
        #1;
        i_reset = 1'b1;
        rspQ.delete();
        modelReset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkResetOutputs("reset_midread");
        end
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_midread_reset", 64'(o_cmd_ready), 64'd1);
        repeat (8) @(posedge clk);
        #1;

        applyStimulus(OP_SETADDR, 0, 5, 32'h0);
        repeat (3) applyStimulus(OP_WRITE, 2, 0, 32'hDEAD_BEEF);
        applyStimulus(OP_READ, 2, 0, 32'h0);
        waitIdle();

        holdReadyLow = 1'b1;
        applyStimulus(OP_SETADDR, 0, 5, 32'h0);
        applyStimulus(OP_READ, 2, 0, 32'h0);
        seen = 1'b0;
        for (int w = 0; w < 30; w++) begin
            @(negedge clk);
            if (o_rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput("rsp_hold_timeout", 64'd0, 64'd1);
        repeat (5) @(posedge clk);
        #1;
        holdReadyLow = 1'b0;
        waitIdle();

        applyStimulus(OP_SETADDR, 0, 10'h3FF, 32'h0);
        applyStimulus(OP_WRITE, 0, 0, 32'h1111_2222);
        applyStimulus(OP_WRITE, 0, 0, 32'h3333_4444);
        applyStimulus(OP_SETADDR, 0, 10'h3FF, 32'h0);
        applyStimulus(OP_READ, 0, 0, 32'h0);
        applyStimulus(OP_READ, 0, 0, 32'h0);
        waitIdle();

        applyStimulus(OP_SETADDR, 0, 20, 32'h0);
        applyStimulus(OP_WRITE, 5, 0, 32'hBAD0_BAD0);
        waitIdle();
        checkOutput("err_set", 64'(o_err), 64'(refErr));
        applyStimulus(OP_WRITE, 1, 0, 32'hCAFE_F00D);
        applyStimulus(OP_READ, 6, 0, 32'h0);
        applyStimulus(OP_SETADDR, 0, 20, 32'h0);
        applyStimulus(OP_READ, 1, 0, 32'h0);
        waitIdle();
        checkOutput("err_sticky", 64'(o_err), 64'(refErr));

        applyStimulus(OP_START, 7, 0, 32'h0);
        @(negedge clk);
        checkOutput("start_pulse", 64'(o_start), 64'd1);
        checkOutput("ready_during_start", 64'(o_cmd_ready), 64'd1);
        @(negedge clk);
        checkOutput("start_one_cycle", 64'(o_start), 64'd0);
        @(posedge clk);
        #1;

`ifdef SCIM_MEMBR_WRCNT_EN
        applyStimulus(OP_SETADDR, 0, 100, 32'h0);
        for (int i = 0; i < 10; i++) applyStimulus(OP_WRITE, i % NUM_BANKS, 0, $urandom);
        waitIdle();
        checkOutput("wr_count_10", 64'(o_wr_count), 64'(refWrCount));
`endif

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            op = (r < 4) ? OP_WRITE : (r < 7) ? OP_READ : (r < 9) ? OP_SETADDR : OP_START;
            bank = ($urandom_range(0, 9) == 0) ? $urandom_range(NUM_BANKS, 7) : $urandom_range(0, NUM_BANKS - 1);
            addr = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 3, DEPTH - 1) : $urandom_range(0, 31);
            applyStimulus(op, bank, addr, $urandom);
        end
        waitIdle();

        checkOutput("final_err", 64'(o_err), 64'(refErr));
        checkOutput("final_acc_queue", 64'(accQ.size()), 64'd0);
        checkOutput("final_rsp_queue", 64'(rspQ.size()), 64'd0);
        checkOutput("final_starts", 64'(startsSeen), 64'(startsIssued));
`ifdef SCIM_MEMBR_WRCNT_EN
        checkOutput("final_wr_count", 64'(o_wr_count), 64'(refWrCount));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
